ksadd16b_arb: RTL and testbench
===============================

Name: ksadd16b_arb

Overview:
- Round-robin arbiter and sequencer that shares one 16-bit Kogge-Stone adder (ksadd16b, instantiated inside) between NREQ requesters.
- Each requester offers operands through a valid/ready handshake. The block grants one requester, registers its operands, and drives the adder's bit-level k/t/cin inputs from those registers.
- It captures s0..s16 and returns sum, carry and requester ID through a valid/ready response port.
- Sits between client blocks and the single adder so the adder is never driven by more than one source.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester-ID width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_a  input  16*NREQ  operand A, requester i at bits [16i+15:16i].
- req_b  input  16*NREQ  operand B, same packing.
- req_cin  input  NREQ  per-requester carry-in.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accept.
- rsp_sum  output  16  sum (s15..s0).
- rsp_cout  output  1  carry out (s16).
- rsp_id  output  IDW  index of the requester that owns the result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, rr_ptr=0, operand registers=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0, req_ready=0.
- FSM states: IDLE, ADD, RESP.
- IDLE, arbitration:
  - Search req_valid starting at rr_ptr, incrementing mod NREQ; the first set bit is grant g.
  - req_ready[g]=1 combinationally in the same cycle (a Mealy output of IDLE plus the valid vector). All other req_ready bits are 0.
  - On that edge, capture req_a[g], req_b[g], req_cin[g] and g into registers, then go to ADD.
  - If no valid bit is set, stay in IDLE.
- ADD:
  - The adder inputs are the captured registers and are stable for the whole cycle.
  - At the end of the cycle, register s15..s0 into rsp_sum, s16 into rsp_cout and g into rsp_id, set rsp_valid=1, and go to RESP.
  - req_ready is all-zero.
- RESP:
  - Hold rsp_* stable while rsp_ready=0.
  - On rsp_ready=1: clear rsp_valid, set rr_ptr=(g+1) mod NREQ, and go to IDLE.
  - rsp_sum, rsp_cout and rsp_id keep their last values after rsp_valid drops.
- Latency and throughput:
  - Accept to rsp_valid is 2 cycles.
  - Minimum spacing between accepts is 3 cycles (IDLE, ADD, RESP with rsp_ready held high).
- Fairness:
  - A requester that holds valid is granted within NREQ grants.
  - A requester that drops valid before it is granted is skipped with no penalty.
  - req_valid may drop at any time without ready; it is not sampled outside IDLE.
- Arithmetic:
  - {rsp_cout, rsp_sum} = A + B + cin, unsigned 17-bit result.
  - 0xFFFF+0x0000+1 wraps to sum 0x0000, cout 1.
- Reset mid-operation: rst in ADD or RESP aborts immediately to the reset values. The in-flight result is discarded and rr_ptr returns to 0.
- Rule for req_valid bits at index >= NREQ: not applicable. Grant indices are always < NREQ.

Optional Feature:
- Macro: KSADD16B_ARB_OVF_EN.
- When defined:
  - Adds output port rsp_ovf (1 bit), the two's-complement overflow of the captured operands: (a15==b15) && (s15!=a15).
  - Registered in ADD alongside rsp_sum.
  - Reset value 0; held with the other rsp_* fields.
- When undefined:
  - The port is absent and the logic is omitted.
  - All other behaviour is identical.

Decomposition:
- Shared package/include ksadd16b_arb_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_ADD=2'd1, ST_RESP=2'd2;
  - operand width constant KS_W=16.
- One natural sub-module: rr_arbiter.
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant and encoded grant index.
- The ksadd16b instance stays in the top module, with the bit-level port hookup from the operand registers.

Test Plan:
- Reset in place: after rst, all outputs 0 and busy=0. Req0 then sends A=0x1234, B=0x0F0F, cin=0 → req_ready[0] high in the valid cycle, rsp_valid 2 cycles later, sum=0x2143, cout=0, id=0.
- Carry wrap: req2 sends A=0xFFFF, B=0x0000, cin=1 → sum=0x0000, cout=1, id=2. With OVF_EN, A=0x7FFF, B=0x0001 → ovf=1.
- Round-robin: all four valid continuously, rsp_ready=1 → grant order 0,1,2,3,0. Each result id matches its operands, and accepts are spaced 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_* stable and no req_ready asserted. Releasing rsp_ready → exactly one handshake, then IDLE.
- Reset mid-operation: rst asserted in ADD while req1 is in flight → next cycle rsp_valid=0 and rr_ptr=0. A later simultaneous req1/req3 gives grant 1 first.
- Withdrawn request: req1 valid for one cycle while req0 is being serviced, then dropped → req1 never gets ready. The next grant goes to the next valid index.

Source files
------------

// File: rtl/ksadd16b_arb_pkg.sv
// ksadd16b_arb_pkg
//   Shared definitions for the ksadd16b_arb adder-sharing block.
//   - KS_W     : operand width of the shared Kogge-Stone adder.
//   - state_t  : sequencer states. The encodings are fixed so that external
//                checkers can decode the state.
//   - wrap_inc : modulo-n increment, used to advance the round-robin pointer.
// Optional feature macro used by the top: KSADD16B_ARB_OVF_EN.
package ksadd16b_arb_pkg;

  localparam int KS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ksadd16b.sv
// ksadd16b
//   16-bit Kogge-Stone parallel-prefix adder with carry-in. It is purely
//   combinational.
// Ports:
//   k   [15:0] in  : operand A bits (bit i is k_i)
//   t   [15:0] in  : operand B bits (bit i is t_i)
//   cin        in  : carry-in
//   s   [16:0] out : s[15:0] is the sum and s[16] is the carry-out
module ksadd16b (
  input  logic [15:0] k,
  input  logic [15:0] t,
  input  logic        cin,
  output logic [16:0] s
);

  logic [15:0] gen;
  logic [15:0] prop;
  logic [15:0] gg;
  logic [15:0] pp;
  logic [16:0] c;

  always_comb begin
    gen  = k & t;
    prop = k ^ t;
    gg   = gen;
    pp   = prop;
    // Four prefix levels with spans 1, 2, 4 and 8. Walking each level from
    // the MSB down updates the vectors in place, because bit i only reads
    // bit i-span, and that bit has not been overwritten yet at this level.
    for (int l = 0; l < 4; l++) begin
      for (int i = 15; i >= 0; i--) begin
        if (i >= (1 << l)) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
          pp[i] = pp[i] & pp[i - (1 << l)];
        end
      end
    end
    // The carry-in acts as a generate that enters below bit 0.
    c[0] = cin;
    for (int i = 0; i < 16; i++) begin
      c[i + 1] = gg[i] | (pp[i] & cin);
    end
    s = {c[16], prop ^ c[15:0]};
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. It searches req upward from ptr,
//   wrapping modulo NREQ. The first set bit wins.
// Ports:
//   req     [NREQ-1:0] in  : request vector
//   ptr     [IDW-1:0]  in  : highest-priority index (always < NREQ)
//   en                 in  : arbitration enable; with en low, all outputs are 0
//   gnt     [NREQ-1:0] out : one-hot grant
//   gnt_idx [IDW-1:0]  out : encoded grant index (0 when nothing is granted)
//   any                out : some request was granted
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  logic [IDW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = ptr;
    if (en) begin
      for (int n = 0; n < NREQ; n++) begin
        if (!any && req[idx]) begin
          any     = 1'b1;
          gnt_idx = idx;
        end
        idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + IDW'(1);
      end
      if (any) gnt = NREQ'(1) << gnt_idx;
    end
  end

endmodule

// File: rtl/ksadd16b_arb.sv
// ksadd16b_arb
//   This block shares one ksadd16b adder between NREQ requesters. An idle
//   cycle arbitrates round-robin and captures the winner's operands. The
//   ADD cycle evaluates the adder from those registers and latches the
//   result. RESP then holds the result until the consumer accepts it.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both high. req_ready is a combinational function of the IDLE state
//   and req_valid. req_valid may drop at any time and is ignored outside
//   IDLE. rsp_valid stays high, with rsp_* stable, until rsp_ready is seen.
//
// Ports:
//   clk, rst                 : clock; synchronous active-high reset
//   req_valid/req_ready      : per-requester operand handshake (NREQ each)
//   req_a, req_b [16*NREQ]   : operands; requester i uses bits [16i+15:16i]
//   req_cin [NREQ]           : per-requester carry-in
//   rsp_valid/rsp_ready      : result handshake
//   rsp_sum [16], rsp_cout   : A + B + cin
//   rsp_id [IDW]             : requester that owns the result
//   busy                     : state is not IDLE
//   rsp_ovf (only with KSADD16B_ARB_OVF_EN) : signed overflow of A + B + cin
module ksadd16b_arb
  import ksadd16b_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [KS_W*NREQ-1:0] req_a,
  input  logic [KS_W*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]      req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [KS_W-1:0]      rsp_sum,
  output logic                 rsp_cout,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
`ifdef KSADD16B_ARB_OVF_EN
  ,
  output logic                 rsp_ovf
`endif
);

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [KS_W-1:0] op_a;
  logic [KS_W-1:0] op_b;
  logic            op_cin;
  logic [IDW-1:0]  op_id;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [KS_W-1:0] sel_a;
  logic [KS_W-1:0] sel_b;
  logic            sel_cin;
  logic [KS_W:0]   s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (state == ST_IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // The arbiter is enabled only in IDLE, so gnt is already zero elsewhere.
  assign req_ready = gnt;
  assign busy      = (state != ST_IDLE);

  // Operand mux keyed by the one-hot grant.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a   = req_a[i*KS_W +: KS_W];
        sel_b   = req_b[i*KS_W +: KS_W];
        sel_cin = req_cin[i];
      end
    end
  end

  // The adder is driven only from the operand registers, so its inputs
  // hold steady for the whole ADD cycle.
  ksadd16b u_add (
    .k   (op_a),
    .t   (op_b),
    .cin (op_cin),
    .s   (s)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (gnt_any)   state_nxt = ST_ADD;
      ST_ADD:                 state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
      op_id  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && gnt_any) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        op_cin <= sel_cin;
        op_id  <= gnt_idx;
      end
      // The pointer advances only when the response completes, so an
      // aborted operation never changes the arbitration order.
      if (state == ST_RESP && rsp_ready) begin
        rr_ptr <= IDW'(wrap_inc(int'(op_id), NREQ));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      if (state == ST_ADD) begin
        rsp_valid <= 1'b1;
        rsp_sum   <= s[KS_W-1:0];
        rsp_cout  <= s[KS_W];
        rsp_id    <= op_id;
      end else if (state == ST_RESP && rsp_ready) begin
        // Only valid drops. The data fields keep their last values.
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef KSADD16B_ARB_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_ovf <= 1'b0;
    end else if (state == ST_ADD) begin
      rsp_ovf <= (op_a[KS_W-1] == op_b[KS_W-1]) && (s[KS_W-1] != op_a[KS_W-1]);
    end
  end
`endif

endmodule

// File: tb/tb_ksadd16b_arb.sv
// tb_ksadd16b_arb
//   Self-checking bench for ksadd16b_arb. Expected grants come from a
//   round-robin search over the offered valid vector. Expected results come
//   from plain integer arithmetic. Define KSADD16B_ARB_OVF_EN to also check
//   rsp_ovf.
module tb_ksadd16b_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = 1 + IDW + 17;  // {ovf, id, cout, sum}

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [16*NREQ-1:0]   req_a;
  logic [16*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_cin;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [15:0]          rsp_sum;
  logic                 rsp_cout;
  logic [IDW-1:0]       rsp_id;
  logic                 busy;
`ifdef KSADD16B_ARB_OVF_EN
  logic                 rsp_ovf;
`endif

  ksadd16b_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef KSADD16B_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bench state ----------------
  logic [15:0]  op_a   [NREQ];
  logic [15:0]  op_b   [NREQ];
  logic         op_cin [NREQ];
  logic [W-1:0] exp_q[$];
  int           model_ptr   = 0;
  int           last_acc    = 0;
  bit           chk_spacing = 1'b0;
  int           n_checks    = 0;
  int           n_pass      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [NREQ-1:0] v);
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*16 +: 16] = op_a[i];
      req_b[i*16 +: 16] = op_b[i];
      req_cin[i]        = op_cin[i];
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
    op_a[i]   = a;
    op_b[i]   = b;
    op_cin[i] = c;
  endtask

  // Reference model: the first valid requester at or after the pointer, wrapping.
  function automatic int model_grant(input logic [NREQ-1:0] v);
    for (int n = 0; n < NREQ; n++) begin
      if (v[(model_ptr + n) % NREQ]) return (model_ptr + n) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] expect_result(input int g);
    int unsigned    tot;
    int             sres;
    logic           ovf;
    logic [IDW-1:0] id;
    tot  = 32'(op_a[g]) + 32'(op_b[g]) + 32'(op_cin[g]);
    sres = int'($signed(op_a[g])) + int'($signed(op_b[g])) + int'(op_cin[g]);
    ovf  = (sres > 32767) || (sres < -32768);
    id   = IDW'(g);
    return {ovf, id, tot[16:0]};
  endfunction

  task automatic check_rsp(input string tag, input logic [W-1:0] e);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_sum"},   32'(rsp_sum),   32'(e[15:0]));
    chk({tag, "_cout"},  32'(rsp_cout),  32'(e[16]));
    chk({tag, "_id"},    32'(rsp_id),    32'(e[17 +: IDW]));
`ifdef KSADD16B_ARB_OVF_EN
    chk({tag, "_ovf"},   32'(rsp_ovf),   32'(e[17+IDW]));
`endif
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  // One full transaction, called just after a rising edge while the DUT is idle.
  // v0 is offered in the arbitration cycle, v1 during ADD and v2 during RESP.
  // RESP is held for `hold` cycles before rsp_ready is asserted.
  task automatic do_txn(input logic [NREQ-1:0] v0, input logic [NREQ-1:0] v1,
                        input logic [NREQ-1:0] v2, input int hold, input bit gap);
    int              g;
    logic [NREQ-1:0] oh;
    logic [W-1:0]    e;
    drive_req(v0);
    rsp_ready = 1'b0;
    @(negedge clk);
    g = model_grant(v0);
    if (g < 0) begin
      chk("idle_ready", 32'(req_ready), 32'd0);
      chk("idle_busy",  32'(busy),      32'd0);
      tick();
      return;
    end
    oh    = '0;
    oh[g] = 1'b1;
    chk("grant", 32'(req_ready), 32'(oh));
    if (chk_spacing) chk("spacing", 32'(cyc - last_acc), 32'd3);
    last_acc = cyc;
    exp_q.push_back(expect_result(g));
    tick();
    drive_req(v1);
    @(negedge clk);
    chk("add_ready", 32'(req_ready), 32'd0);
    chk("add_valid", 32'(rsp_valid), 32'd0);
    chk("add_busy",  32'(busy),      32'd1);
    tick();
    drive_req(v2);
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) rsp_ready = 1'b1;
      @(negedge clk);
      check_rsp("resp", exp_q[0]);
      tick();
    end
    rsp_ready = 1'b0;
    e = exp_q.pop_front();
    model_ptr = (g + 1) % NREQ;
    if (gap) begin
      drive_req('0);
      @(negedge clk);
      chk("post_valid", 32'(rsp_valid), 32'd0);
      chk("post_busy",  32'(busy),      32'd0);
      chk("post_sum",   32'(rsp_sum),   32'(e[15:0]));
      chk("post_id",    32'(rsp_id),    32'(e[17 +: IDW]));
      tick();
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_sum"},   32'(rsp_sum),   32'd0);
    chk({tag, "_cout"},  32'(rsp_cout),  32'd0);
    chk({tag, "_id"},    32'(rsp_id),    32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
`ifdef KSADD16B_ARB_OVF_EN
    chk({tag, "_ovf"},   32'(rsp_ovf),   32'd0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    for (int i = 0; i < NREQ; i++) set_op(i, 16'h0, 16'h0, 1'b0);

    // Reset in place
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    tick();
    model_ptr = 0;

    // Basic add on requester 0
    set_op(0, 16'h1234, 16'h0F0F, 1'b0);
    do_txn(4'b0001, 4'b0000, 4'b0000, 0, 1'b1);

    // Carry wrap on requester 2
    set_op(2, 16'hFFFF, 16'h0000, 1'b1);
    do_txn(4'b0100, 4'b0000, 4'b0000, 0, 1'b1);

    // Signed overflow operands on requester 1
    set_op(1, 16'h7FFF, 16'h0001, 1'b0);
    do_txn(4'b0010, 4'b0000, 4'b0000, 0, 1'b1);

    // Round-robin with all requesters valid and back-to-back accepts
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < NREQ; i++) set_op(i, 16'(16'h1000 * (i + 1)), 16'(16'h0101 * (i + 3)), i[0]);
    for (int n = 0; n < 5; n++) begin
      chk_spacing = (n > 0);
      do_txn(4'b1111, 4'b1111, 4'b1111, 0, (n == 4));
    end
    chk_spacing = 1'b0;

    // Backpressure: five stalled RESP cycles
    set_op(3, 16'hA5A5, 16'h5A5A, 1'b1);
    do_txn(4'b1000, 4'b1111, 4'b1111, 5, 1'b1);

    // Withdrawn request: req1 is valid only while req0 is serviced
    set_op(0, 16'h0042, 16'h0058, 1'b0);
    do_txn(4'b0001, 4'b0010, 4'b0000, 1, 1'b1);
    set_op(0, 16'h1111, 16'h2222, 1'b0);
    set_op(3, 16'h8000, 16'h8000, 1'b0);
    do_txn(4'b1001, 4'b0000, 4'b0000, 0, 1'b1);

    // Reset mid-operation: move the pointer to 3, then abort req1 in ADD
    set_op(2, 16'h0F00, 16'h00F0, 1'b0);
    do_txn(4'b0100, 4'b0000, 4'b0000, 0, 1'b1);
    set_op(1, 16'hBEEF, 16'h1111, 1'b1);
    drive_req(4'b0010);
    @(negedge clk);
    chk("abort_grant", 32'(req_ready), 32'b0010);
    tick();
    drive_req('0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("abort");
    tick();
    model_ptr = 0;
    set_op(3, 16'h0003, 16'h0004, 1'b0);
    do_txn(4'b1010, 4'b0000, 4'b0000, 0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) set_op(i, 16'hFFFF, 16'(($urandom_range(0, 1)) ? 16'hFFFF : 16'h0000), 1'($urandom_range(0, 1)));
        else set_op(i, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      end
      do_txn(NREQ'($urandom_range(0, (1 << NREQ) - 1)),
             NREQ'($urandom_range(0, (1 << NREQ) - 1)),
             NREQ'($urandom_range(0, (1 << NREQ) - 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
